lpddr4_ca_serializer: RTL and testbench



---
 rtl/lpddr4_pkg.sv | 84 ++++++++
 rtl/lpddr4_tick_fifo.sv | 76 +++++++
 rtl/lpddr4_ca_serializer.sv | 97 +++++++++
 tb/tb_lpddr4_ca_serializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lpddr4_pkg.sv
// Shared types and command encoders for the LPDDR4 CA serializer.
// Each encoder returns up to four {cs, ca} ticks plus the number of valid ticks.
package lpddr4_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6,
    CMD_REFA = 3'd7
  } cmd_type_e;

  typedef struct packed {
    logic       cs;
    logic [5:0] ca;
  } ca_tick_t;

  typedef ca_tick_t [3:0] tick_arr_t;

  typedef struct packed {
    tick_arr_t  ticks;
    logic [2:0] n;
  } enc_t;

  localparam logic [2:0] MAX_TICKS = 3'd4;

  function automatic ca_tick_t mk_tick(input logic cs, input logic [5:0] ca);
    ca_tick_t t;
    t.cs = cs;
    t.ca = ca;
    return t;
  endfunction

  // Concatenations are written CA5..CA0 so that ca[i] carries CAi.
  function automatic enc_t enc_act(input logic [2:0] ba, input logic [15:0] r);
    enc_t e;
    e.n        = MAX_TICKS;
    e.ticks[0] = mk_tick(1'b1, {r[15], r[14], r[13], r[12], 1'b0, 1'b1});
    e.ticks[1] = mk_tick(1'b0, {r[10], r[11], 1'b0, ba[2], ba[1], ba[0]});
    e.ticks[2] = mk_tick(1'b1, {r[9], r[8], r[7], r[6], 1'b1, 1'b1});
    e.ticks[3] = mk_tick(1'b0, r[5:0]);
    return e;
  endfunction

  // c holds column bits C9..C2 (c[0] is C2).
  function automatic enc_t enc_cas(input logic is_wr, input logic [2:0] ba,
                                   input logic [7:0] c, input logic bl, input logic ap);
    enc_t e;
    e.n = MAX_TICKS;
    if (is_wr) begin
      e.ticks[0] = mk_tick(1'b1, {bl, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    end else begin
      e.ticks[0] = mk_tick(1'b1, {bl, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    e.ticks[1] = mk_tick(1'b0, {ap, c[7], 1'b0, ba[2], ba[1], ba[0]});
    e.ticks[2] = mk_tick(1'b1, {c[6], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    e.ticks[3] = mk_tick(1'b0, c[5:0]);
    return e;
  endfunction

  function automatic enc_t enc_pre_ref(input logic is_ref, input logic ab, input logic [2:0] ba);
    enc_t e;
    e.n = 3'd2;
    if (is_ref) begin
      e.ticks[0] = mk_tick(1'b1, {ab, 1'b0, 1'b1, 3'b000});
    end else begin
      e.ticks[0] = mk_tick(1'b1, {ab, 1'b1, 4'b0000});
    end
    e.ticks[1] = mk_tick(1'b0, {3'b000, ba});
    e.ticks[2] = '0;
    e.ticks[3] = '0;
    return e;
  endfunction

  function automatic enc_t enc_nop();
    enc_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/lpddr4_tick_fifo.sv
// Tick FIFO: up to four writes and NPHASES in-order reads per cycle.
// Reads are combinational; phases beyond the available count read as DES.
module lpddr4_tick_fifo
  import lpddr4_pkg::*;
#(
  parameter int NPHASES = 4,
  parameter int DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    wr_n,
  input  tick_arr_t                     wr_data,
  output ca_tick_t [NPHASES-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(DEPTH):0]        count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ca_tick_t          mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     rd_n_s;
  logic [CW-1:0]     count_next_s;

  // Number of ticks drained this cycle and resulting occupancy.
  always_comb begin
    rd_n_s = CW'(NPHASES);
    if (count_r < CW'(NPHASES)) begin
      rd_n_s = count_r;
    end else begin
      rd_n_s = CW'(NPHASES);
    end
    count_next_s = count_r + CW'(wr_n) - rd_n_s;
  end

  // Pointer and occupancy state; the upstream handshake guarantees no overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(wr_n);
      rd_ptr_r <= rd_ptr_r + AW'(rd_n_s);
      count_r  <= count_next_s;
    end
  end

  // Tick storage; all ticks of one command land in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < wr_n) begin
        mem_r[wr_ptr_r + AW'(i)] <= wr_data[i];
      end
    end
  end

  // Per-phase read data, DES where no tick is available.
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < NPHASES; j++) begin
      if (CW'(j) < rd_n_s) begin
        rd_data[j] = mem_r[rd_ptr_r + AW'(j)];
      end else begin
        rd_data[j] = '0;
      end
    end
  end

  assign count      = count_r;
  assign count_next = count_next_s;

endmodule

// File: rtl/lpddr4_ca_serializer.sv
// LPDDR4 CA serializer: encodes one command per sys_clk into CS/CA ticks
// and streams them contiguously, NPHASES ticks per cycle, onto the DFI phases.
module lpddr4_ca_serializer
  import lpddr4_pkg::*;
#(
  parameter int NPHASES    = 4,
  parameter int TICK_DEPTH = 16,
  parameter int ROW_W      = 16,
  parameter int COL_W      = 10
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_type,
  input  logic [2:0]             cmd_bank,
  input  logic [ROW_W-1:0]       cmd_row,
  input  logic [COL_W-1:0]       cmd_col,
  input  logic                   cmd_bl,
  input  logic                   cmd_ap,
  output logic [NPHASES-1:0]     dfi_cs,
  output logic [6*NPHASES-1:0]   dfi_ca,
  output logic                   busy
);

  localparam int CW = $clog2(TICK_DEPTH) + 1;

  logic [15:0]            row16_s;
  logic [9:0]             col10_s;
  logic                   unused_col_s;
  enc_t                   enc_s;
  logic                   acc_s;
  logic [2:0]             wr_n_s;
  ca_tick_t [NPHASES-1:0] rd_data_s;
  logic [CW-1:0]          count_s;
  logic [CW-1:0]          count_next_s;

  assign row16_s      = 16'(cmd_row);
  assign col10_s      = 10'(cmd_col);
  assign unused_col_s = &{1'b0, col10_s[1:0]};

  // Command encoding.
  always_comb begin
    enc_s = enc_nop();
    case (cmd_type_e'(cmd_type))
      CMD_ACT:  enc_s = enc_act(cmd_bank, row16_s);
      CMD_RD:   enc_s = enc_cas(1'b0, cmd_bank, col10_s[9:2], cmd_bl, cmd_ap);
      CMD_WR:   enc_s = enc_cas(1'b1, cmd_bank, col10_s[9:2], cmd_bl, cmd_ap);
      CMD_PRE:  enc_s = enc_pre_ref(1'b0, 1'b0, cmd_bank);
      CMD_PREA: enc_s = enc_pre_ref(1'b0, 1'b1, cmd_bank);
      CMD_REF:  enc_s = enc_pre_ref(1'b1, 1'b0, cmd_bank);
      CMD_REFA: enc_s = enc_pre_ref(1'b1, 1'b1, cmd_bank);
      default:  enc_s = enc_nop();
    endcase
  end

  // Accepted commands enqueue all their ticks at once; NOP enqueues none.
  always_comb begin
    acc_s = cmd_valid & cmd_ready;
    if (acc_s) begin
      wr_n_s = enc_s.n;
    end else begin
      wr_n_s = 3'd0;
    end
  end

  lpddr4_tick_fifo #(
    .NPHASES (NPHASES),
    .DEPTH   (TICK_DEPTH)
  ) u_fifo (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .wr_n       (wr_n_s),
    .wr_data    (enc_s.ticks),
    .rd_data    (rd_data_s),
    .count      (count_s),
    .count_next (count_next_s)
  );

  // Registered DFI outputs and handshake; ready tracks the occupancy the FIFO will hold.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      dfi_cs    <= '0;
      dfi_ca    <= '0;
    end else begin
      cmd_ready <= (CW'(TICK_DEPTH) - count_next_s) >= CW'(4);
      busy      <= (count_s != '0);
      for (int j = 0; j < NPHASES; j++) begin
        dfi_cs[j]         <= rd_data_s[j].cs;
        dfi_ca[6*j +: 6]  <= rd_data_s[j].ca;
      end
    end
  end

endmodule

// File: tb/tb_lpddr4_ca_serializer.sv
// Directed bench for lpddr4_ca_serializer at NPHASES 4, 2 and 1 (depth 8),
// checking every phase of every cycle against hand-computed tick tables.
module tb_lpddr4_ca_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v4, v2, v1;
  logic [2:0]  ctype, cbank;
  logic [15:0] crow;
  logic [9:0]  ccol;
  logic        cbl, cap;
  logic        rdy4, rdy2, rdy1, busy4, busy2, busy1;
  logic [3:0]  cs4;
  logic [23:0] ca4;
  logic [1:0]  cs2;
  logic [11:0] ca2;
  logic [0:0]  cs1;
  logic [5:0]  ca1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [6:0]  exp_tk [6][4];
  int          exp_n  [6];
  int          seq[$];
  bit          low_seen;

  always #5 clk = ~clk;

  lpddr4_ca_serializer #(.NPHASES(4), .TICK_DEPTH(16)) u4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .cmd_valid(v4), .cmd_ready(rdy4),
    .cmd_type(ctype), .cmd_bank(cbank), .cmd_row(crow), .cmd_col(ccol),
    .cmd_bl(cbl), .cmd_ap(cap), .dfi_cs(cs4), .dfi_ca(ca4), .busy(busy4));

  lpddr4_ca_serializer #(.NPHASES(2), .TICK_DEPTH(16)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .cmd_valid(v2), .cmd_ready(rdy2),
    .cmd_type(ctype), .cmd_bank(cbank), .cmd_row(crow), .cmd_col(ccol),
    .cmd_bl(cbl), .cmd_ap(cap), .dfi_cs(cs2), .dfi_ca(ca2), .busy(busy2));

  lpddr4_ca_serializer #(.NPHASES(1), .TICK_DEPTH(8)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_type(ctype), .cmd_bank(cbank), .cmd_row(crow), .cmd_col(ccol),
    .cmd_bl(cbl), .cmd_ap(cap), .dfi_cs(cs1), .dfi_ca(ca1), .busy(busy1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Command vectors: 0 ACT b3 r=A5C3, 1 RD b2 c=3F4 bl0 ap1, 2 WR same, 3 PREA, 4 REFA, 5 NOP.
  task automatic drive(input int id, input int inst, input logic v);
    case (id)
      0: begin ctype = 3'd1; cbank = 3'd3; crow = 16'hA5C3; ccol = 10'h000; cbl = 1'b0; cap = 1'b0; end
      1: begin ctype = 3'd2; cbank = 3'd2; crow = 16'h0000; ccol = 10'h3F4; cbl = 1'b0; cap = 1'b1; end
      2: begin ctype = 3'd3; cbank = 3'd2; crow = 16'h0000; ccol = 10'h3F4; cbl = 1'b0; cap = 1'b1; end
      3: begin ctype = 3'd5; cbank = 3'd0; crow = 16'hFFFF; ccol = 10'h3FF; cbl = 1'b1; cap = 1'b0; end
      4: begin ctype = 3'd7; cbank = 3'd0; crow = 16'hFFFF; ccol = 10'h3FF; cbl = 1'b1; cap = 1'b0; end
      default: begin ctype = 3'd0; cbank = 3'd7; crow = 16'hFFFF; ccol = 10'h3FF; cbl = 1'b1; cap = 1'b1; end
    endcase
    v4 = v && (inst == 0);
    v2 = v && (inst == 1);
    v1 = v && (inst == 2);
  endtask

  task automatic sample(input int inst, output logic [7:0] ocs, output logic [47:0] oca,
                        output logic ordy, output logic obusy);
    case (inst)
      0: begin ocs = {4'b0, cs4}; oca = {24'b0, ca4}; ordy = rdy4; obusy = busy4; end
      1: begin ocs = {6'b0, cs2}; oca = {36'b0, ca2}; ordy = rdy2; obusy = busy2; end
      default: begin ocs = {7'b0, cs1}; oca = {42'b0, ca1}; ordy = rdy1; obusy = busy1; end
    endcase
  endtask

  // Offers seq[] to one instance, checking ready, busy and every phase each cycle.
  task automatic run_seq(input int inst, output bit saw_low);
    int         np, depth, idx, m_cnt, k, cyc;
    bit         acc, busy_exp;
    logic [6:0] expq[$];
    logic [6:0] t;
    logic [7:0] ocs;
    logic [47:0] oca;
    logic       ordy, obusy;
    np = (inst == 0) ? 4 : (inst == 1) ? 2 : 1;
    depth = (inst == 2) ? 8 : 16;
    idx = 0; m_cnt = 0; cyc = 0; saw_low = 1'b0;
    while (cyc < 300) begin
      sample(inst, ocs, oca, ordy, obusy);
      chk("ready", 64'(ordy), 64'((depth - m_cnt) >= 4));
      if (!ordy) saw_low = 1'b1;
      if (idx < seq.size()) drive(seq[idx], inst, 1'b1);
      else drive(5, inst, 1'b0);
      acc = (idx < seq.size()) && ordy;
      @(posedge clk); #1;
      k = (m_cnt < np) ? m_cnt : np;
      busy_exp = (m_cnt != 0);
      sample(inst, ocs, oca, ordy, obusy);
      for (int j = 0; j < np; j++) begin
        t = (j < k) ? expq.pop_front() : 7'd0;
        chk($sformatf("p%0d_cs", j), 64'(ocs[j]), 64'(t[6]));
        chk($sformatf("p%0d_ca", j), 64'(oca[6*j +: 6]), 64'(t[5:0]));
      end
      chk("busy", 64'(obusy), 64'(busy_exp));
      m_cnt = m_cnt - k;
      if (acc) begin
        for (int i = 0; i < exp_n[seq[idx]]; i++) expq.push_back(exp_tk[seq[idx]][i]);
        m_cnt = m_cnt + exp_n[seq[idx]];
        idx++;
      end
      cyc++;
      if (idx == seq.size() && m_cnt == 0 && !busy_exp) break;
    end
    drive(5, inst, 1'b0);
    chk("drained", 64'({idx == seq.size(), m_cnt == 0}), 64'(2'b11));
  endtask

  initial begin
    exp_tk[0] = '{7'h40 | 7'h29, 7'h23, 7'h40 | 7'h1F, 7'h03}; exp_n[0] = 4;
    exp_tk[1] = '{7'h40 | 7'h02, 7'h32, 7'h40 | 7'h32, 7'h3D}; exp_n[1] = 4;
    exp_tk[2] = '{7'h40 | 7'h04, 7'h32, 7'h40 | 7'h32, 7'h3D}; exp_n[2] = 4;
    exp_tk[3] = '{7'h40 | 7'h30, 7'h00, 7'h00, 7'h00};         exp_n[3] = 2;
    exp_tk[4] = '{7'h40 | 7'h28, 7'h00, 7'h00, 7'h00};         exp_n[4] = 2;
    exp_tk[5] = '{7'h00, 7'h00, 7'h00, 7'h00};                 exp_n[5] = 0;

    rst_n = 1'b0;
    drive(5, 0, 1'b0);
    #2;
    chk("rst_cs4", 64'(cs4), 64'(0));
    chk("rst_ca4", 64'(ca4), 64'(0));
    chk("rst_rdy4", 64'(rdy4), 64'(0));
    chk("rst_busy4", 64'(busy4), 64'(0));
    chk("rst_rdy1", 64'(rdy1), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    seq = '{0};          run_seq(0, low_seen);
    seq = '{1, 2};       run_seq(0, low_seen);
    seq = '{3, 4};       run_seq(0, low_seen);
    seq = '{0, 1, 2, 0, 1, 2, 0, 1};
    run_seq(1, low_seen);
    chk("np2_ready_dropped", 64'(low_seen), 64'(1));
    seq = '{0, 0, 0, 0};
    run_seq(2, low_seen);
    chk("np1_ready_dropped", 64'(low_seen), 64'(1));

    // Reset partway through an NPHASES=2 ACT.
    drive(0, 1, 1'b1);
    @(posedge clk); #1;
    drive(5, 1, 1'b0);
    @(posedge clk); #1;
    chk("mid_cs2", 64'(cs2), 64'(2'b01));
    chk("mid_ca2", 64'(ca2), 64'({6'h23, 6'h29}));
    rst_n = 1'b0;
    #1;
    chk("arst_cs2", 64'(cs2), 64'(0));
    chk("arst_ca2", 64'(ca2), 64'(0));
    chk("arst_rdy2", 64'(rdy2), 64'(0));
    chk("arst_busy2", 64'(busy2), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_busy2", 64'(busy2), 64'(0));
    chk("post_rdy2", 64'(rdy2), 64'(1));
    chk("post_cs2", 64'(cs2), 64'(0));
    @(posedge clk); #1;
    chk("post_cs2_b", 64'(cs2), 64'(0));
    seq = '{5, 0};
    run_seq(1, low_seen);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
